// File: rtl/hba_bus_arbiter.sv
// rtl/hba_bus_arbiter.sv - round-robin HBA bus arbiter with transfer watchdog
// One transaction per grant; registered bus outputs forced to zero while hba_select is low.
module hba_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DBUS_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              hba_clk,
  input  logic                              hba_reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_rnw,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_abus,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] m_dbus,
  output logic [NUM_MASTERS-1:0]            m_grant,
  output logic [NUM_MASTERS-1:0]            m_xferack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DBUS_WIDTH-1:0]             m_rdata,
  output logic                              hba_rnw,
  output logic                              hba_select,
  output logic [ADDR_WIDTH-1:0]             hba_abus,
  output logic [DBUS_WIDTH-1:0]             hba_dbus,
  input  logic                              hba_xferack,
  input  logic [DBUS_WIDTH-1:0]             hba_dbus_slave
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]             state_q,   state_d;
  logic [IW-1:0]          rr_q,      rr_d;
  logic [CW-1:0]          cnt_q,     cnt_d;
  logic [NUM_MASTERS-1:0] grant_q,   grant_d;
  logic [NUM_MASTERS-1:0] xferack_q, xferack_d;
  logic [NUM_MASTERS-1:0] err_q,     err_d;
  logic [DBUS_WIDTH-1:0]  rdata_q,   rdata_d;
  logic                   rnw_q,     rnw_d;
  logic                   select_q,  select_d;
  logic [ADDR_WIDTH-1:0]  abus_q,    abus_d;
  logic [DBUS_WIDTH-1:0]  dbus_q,    dbus_d;

  logic                   found;
  logic [IW-1:0]          win;
  logic [IW-1:0]          scan_idx;
  logic                   sel_rnw;
  logic [ADDR_WIDTH-1:0]  sel_abus;
  logic [DBUS_WIDTH-1:0]  sel_dbus;

  // Search upward from the last winner so every requester is served in turn.
  always_comb begin
    found    = 1'b0;
    win      = rr_q;
    scan_idx = rr_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      scan_idx = IW'((int'(rr_q) + i) % NUM_MASTERS);
      if (!found && m_req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_rnw  = 1'b0;
    sel_abus = '0;
    sel_dbus = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (win == IW'(j)) begin
        sel_rnw  = m_rnw[j];
        sel_abus = m_abus[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dbus = m_dbus[j*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    xferack_d = '0;
    err_d     = '0;
    rdata_d   = '0;
    rnw_d     = rnw_q;
    select_d  = select_q;
    abus_d    = abus_q;
    dbus_d    = dbus_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          rr_d          = win;
          cnt_d         = '0;
          select_d      = 1'b1;
          rnw_d         = sel_rnw;
          abus_d        = sel_abus;
          dbus_d        = sel_dbus;
          grant_d       = '0;
          grant_d[win]  = 1'b1;
          state_d       = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A slave ack wins over a coinciding watchdog expiry.
        if (hba_xferack || (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
          xferack_d[rr_q] = 1'b1;
          if (hba_xferack) begin
            rdata_d = rnw_q ? hba_dbus_slave : '0;
          end else begin
            err_d[rr_q] = 1'b1;
          end
          select_d = 1'b0;
          rnw_d    = 1'b0;
          abus_d   = '0;
          dbus_d   = '0;
          grant_d  = '0;
          state_d  = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state_q   <= S_IDLE;
      rr_q      <= IW'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      grant_q   <= '0;
      xferack_q <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      rnw_q     <= 1'b0;
      select_q  <= 1'b0;
      abus_q    <= '0;
      dbus_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      xferack_q <= xferack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rnw_q     <= rnw_d;
      select_q  <= select_d;
      abus_q    <= abus_d;
      dbus_q    <= dbus_d;
    end
  end

  assign m_grant    = grant_q;
  assign m_xferack  = xferack_q;
  assign m_err      = err_q;
  assign m_rdata    = rdata_q;
  assign hba_rnw    = rnw_q;
  assign hba_select = select_q;
  assign hba_abus   = abus_q;
  assign hba_dbus   = dbus_q;

endmodule

// File: tb/tb_hba_bus_arbiter.sv
// tb/tb_hba_bus_arbiter.sv - self-checking bench for hba_bus_arbiter
// Behavioural slave with configurable ack latency; scoreboard checks every completion.
module tb_hba_bus_arbiter;

  logic        hba_clk = 1'b0;
  logic        hba_reset;
  logic [1:0]  m_req;
  logic [1:0]  m_rnw;
  logic [23:0] m_abus;
  logic [15:0] m_dbus;
  logic [1:0]  m_grant;
  logic [1:0]  m_xferack;
  logic [1:0]  m_err;
  logic [7:0]  m_rdata;
  logic        hba_rnw;
  logic        hba_select;
  logic [11:0] hba_abus;
  logic [7:0]  hba_dbus;
  logic        hba_xferack;
  logic [7:0]  hba_dbus_slave;

  int total = 0;
  int bad   = 0;

  hba_bus_arbiter #(
    .NUM_MASTERS(2), .DBUS_WIDTH(8), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .hba_clk(hba_clk), .hba_reset(hba_reset),
    .m_req(m_req), .m_rnw(m_rnw), .m_abus(m_abus), .m_dbus(m_dbus),
    .m_grant(m_grant), .m_xferack(m_xferack), .m_err(m_err), .m_rdata(m_rdata),
    .hba_rnw(hba_rnw), .hba_select(hba_select), .hba_abus(hba_abus), .hba_dbus(hba_dbus),
    .hba_xferack(hba_xferack), .hba_dbus_slave(hba_dbus_slave)
  );

  always #5 hba_clk = ~hba_clk;

  // Slave: register bank at periph 0, or a stub answering every address.
  logic [7:0] regs [256];
  int         slave_lat = 3;
  logic       stub_mode = 1'b0;
  int         sc;
  logic       slave_ack;
  logic       mapped;

  assign mapped         = stub_mode || (hba_abus[11:8] == 4'h0);
  assign hba_xferack    = slave_ack;
  assign hba_dbus_slave = (slave_ack && hba_rnw) ? (stub_mode ? 8'hA7 : regs[hba_abus[7:0]]) : 8'h00;

  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'(i * 7 + 1);
    regs[0] = 8'h11;
    regs[2] = 8'h5A;
  end

  always @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset || !hba_select) begin
      sc        <= 0;
      slave_ack <= 1'b0;
    end else begin
      if (slave_ack && !hba_rnw && !stub_mode) regs[hba_abus[7:0]] <= hba_dbus;
      if (!slave_ack) sc <= sc + 1;
      slave_ack <= !slave_ack && mapped && (sc == slave_lat - 2);
    end
  end

  typedef struct packed {
    logic [1:0] m;
    logic [7:0] d;
    logic       e;
  } exp_t;
  exp_t sb[$];

  always @(negedge hba_clk) begin
    exp_t ex;
    if (m_xferack !== 2'b00) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ack=%b nothing expected", m_xferack);
      end else begin
        ex = sb.pop_front();
        if ({m_xferack, m_rdata, m_err} !== {ex.m, ex.d, (ex.e ? ex.m : 2'b00)}) begin
          bad++;
          $display("FAIL scoreboard: got ack=%b rdata=%h err=%b want ack=%b rdata=%h err=%b",
                   m_xferack, m_rdata, m_err, ex.m, ex.d, (ex.e ? ex.m : 2'b00));
        end
      end
    end
  end

  task automatic set_master(input int m, input logic rnw, input logic [11:0] a, input logic [7:0] d);
    m_rnw[m]           = rnw;
    m_abus[m*12 +: 12] = a;
    m_dbus[m*8 +: 8]   = d;
  endtask

  task automatic push_exp(input int m, input logic [7:0] d, input logic e);
    exp_t ex;
    ex.m = 2'(1 << m);
    ex.d = d;
    ex.e = e;
    sb.push_back(ex);
  endtask

  task automatic do_xfer(input int m, input logic rnw, input logic [11:0] a,
                         input logic [7:0] d, input logic [7:0] ed, input logic ee);
    int n = 0;
    set_master(m, rnw, a, d);
    push_exp(m, ed, ee);
    m_req[m] = 1'b1;
    @(negedge hba_clk);
    while (!m_xferack[m] && n < 100) begin
      @(negedge hba_clk);
      n++;
    end
    total++;
    if (!m_xferack[m]) begin
      bad++;
      $display("FAIL xfer_wait: master %0d got no ack within 100 cycles", m);
    end
    m_req[m] = 1'b0;
  endtask

  task automatic hold_both(input int n_acks);
    int acks = 0;
    int n    = 0;
    m_req = 2'b11;
    while (acks < n_acks && n < 200) begin
      @(negedge hba_clk);
      n++;
      total++;
      if (!$onehot0(m_grant)) begin
        bad++;
        $display("FAIL grant_onehot: got %b want one-hot or zero", m_grant);
      end
      if (m_xferack != 2'b00) acks++;
    end
    m_req = 2'b00;
    total++;
    if (acks != n_acks) begin
      bad++;
      $display("FAIL hold_both_acks: got %0d want %0d", acks, n_acks);
    end
  endtask

  task automatic test_reset;
    hba_reset = 1'b1;
    m_req = '0; m_rnw = '0; m_abus = '0; m_dbus = '0;
    repeat (2) @(negedge hba_clk);
    total++;
    if ({m_grant, m_xferack, m_err, m_rdata} !== 14'd0) begin
      bad++;
      $display("FAIL reset_master_side: got %h want 0", {m_grant, m_xferack, m_err, m_rdata});
    end
    total++;
    if ({hba_rnw, hba_select, hba_abus, hba_dbus} !== 22'd0) begin
      bad++;
      $display("FAIL reset_bus_side: got %h want 0", {hba_rnw, hba_select, hba_abus, hba_dbus});
    end
    hba_reset = 1'b0;
    @(negedge hba_clk);
  endtask

  task automatic test_read;
    set_master(0, 1'b1, 12'h002, 8'h00);
    push_exp(0, 8'h5A, 1'b0);
    m_req[0] = 1'b1;
    @(negedge hba_clk);
    total++;
    if ({hba_select, m_grant, hba_rnw, hba_abus} !== {1'b1, 2'b01, 1'b1, 12'h002}) begin
      bad++;
      $display("FAIL read_start: got sel=%b grant=%b rnw=%b abus=%h want 1 01 1 002",
               hba_select, m_grant, hba_rnw, hba_abus);
    end
    repeat (2) @(negedge hba_clk);
    total++;
    if ({hba_select, m_xferack} !== 3'b100) begin
      bad++;
      $display("FAIL read_wait: got sel=%b ack=%b want 1 00", hba_select, m_xferack);
    end
    @(negedge hba_clk);
    total++;
    if ({m_xferack, m_rdata, m_err, hba_select} !== {2'b01, 8'h5A, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL read_ack: got ack=%b rdata=%h err=%b sel=%b want 01 5a 00 0",
               m_xferack, m_rdata, m_err, hba_select);
    end
    m_req[0] = 1'b0;
    @(negedge hba_clk);
    total++;
    if ({hba_select, m_xferack, m_rdata} !== 11'd0) begin
      bad++;
      $display("FAIL read_release: got sel=%b ack=%b rdata=%h want 0 00 00",
               hba_select, m_xferack, m_rdata);
    end
  endtask

  task automatic test_write_read;
    do_xfer(1, 1'b0, 12'h001, 8'hC3, 8'h00, 1'b0);
    total++;
    if ({hba_select, hba_rnw, hba_abus, hba_dbus} !== 22'd0) begin
      bad++;
      $display("FAIL bus_idle_zero: got sel=%b rnw=%b abus=%h dbus=%h want all 0",
               hba_select, hba_rnw, hba_abus, hba_dbus);
    end
    @(negedge hba_clk);
    do_xfer(1, 1'b1, 12'h001, 8'h00, 8'hC3, 1'b0);
  endtask

  task automatic test_fairness;
    set_master(0, 1'b1, 12'h002, 8'h00);
    set_master(1, 1'b1, 12'h001, 8'h00);
    for (int k = 0; k < 6; k++) push_exp(k % 2, (k % 2 == 0) ? 8'h5A : 8'hC3, 1'b0);
    hold_both(6);
    @(negedge hba_clk);
  endtask

  task automatic test_timeout;
    int active = 0;
    int n      = 0;
    set_master(0, 1'b1, 12'hF00, 8'h00);
    push_exp(0, 8'h00, 1'b1);
    m_req[0] = 1'b1;
    @(negedge hba_clk);
    while (hba_select && n < 100) begin
      active++;
      n++;
      @(negedge hba_clk);
    end
    total++;
    if (active != 16) begin
      bad++;
      $display("FAIL timeout_len: got %0d active cycles want 16", active);
    end
    total++;
    if ({m_xferack, m_err, m_rdata} !== {2'b01, 2'b01, 8'h00}) begin
      bad++;
      $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h want 01 01 00",
               m_xferack, m_err, m_rdata);
    end
    m_req[0] = 1'b0;
    @(negedge hba_clk);
    do_xfer(0, 1'b1, 12'h000, 8'h00, 8'h11, 1'b0);
    @(negedge hba_clk);
  endtask

  task automatic test_ack_on_expiry;
    stub_mode = 1'b1;
    slave_lat = 16;
    do_xfer(1, 1'b1, 12'hF05, 8'h00, 8'hA7, 1'b0);
    total++;
    if (m_err !== 2'b00) begin
      bad++;
      $display("FAIL expiry_err: got err=%b want 00", m_err);
    end
    stub_mode = 1'b0;
    slave_lat = 3;
    @(negedge hba_clk);
  endtask

  task automatic test_async_reset;
    set_master(0, 1'b1, 12'h002, 8'h00);
    m_req[0] = 1'b1;
    @(negedge hba_clk);
    @(negedge hba_clk);
    total++;
    if (hba_select !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: got sel=%b want 1", hba_select);
    end
    #2 hba_reset = 1'b1;
    #1;
    total++;
    if ({m_grant, m_xferack, m_err, m_rdata, hba_rnw, hba_select, hba_abus, hba_dbus} !== 36'd0) begin
      bad++;
      $display("FAIL areset_outputs: got grant=%b sel=%b abus=%h want all 0",
               m_grant, hba_select, hba_abus);
    end
    m_req = 2'b00;
    @(negedge hba_clk);
    hba_reset = 1'b0;
    repeat (4) @(negedge hba_clk);
    total++;
    if ({m_xferack, hba_select} !== 3'b000) begin
      bad++;
      $display("FAIL areset_no_ack: got ack=%b sel=%b want 00 0", m_xferack, hba_select);
    end
    set_master(1, 1'b1, 12'h001, 8'h00);
    push_exp(0, 8'h5A, 1'b0);
    push_exp(1, 8'hC3, 1'b0);
    m_req = 2'b11;
    @(negedge hba_clk);
    total++;
    if (m_grant !== 2'b01) begin
      bad++;
      $display("FAIL areset_first_grant: got %b want 01", m_grant);
    end
    hold_both(2);
    @(negedge hba_clk);
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_read;
    test_fairness;
    test_timeout;
    test_ack_on_expiry;
    test_async_reset;
    repeat (3) @(negedge hba_clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hba_bus_arbiter.md
Name: hba_bus_arbiter

Overview:
- Shares the single HBA bus between NUM_MASTERS requesters, for example a UART command parser and a local sequencer.
- Grants are round-robin, one transaction per grant.
- The arbiter drives the registered master-side HBA bus signals (hba_rnw, hba_select, hba_abus, hba_dbus) toward all slaves. It returns the slave ack and read data to the granted master.
- A watchdog terminates transfers that no slave acknowledges, flagging an error.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..4).
- DBUS_WIDTH, 8, data bus width.
- ADDR_WIDTH, 12, full HBA address width (periph + reg).
- TIMEOUT_CYCLES, 16, cycles hba_select may stay high without hba_xferack before forced termination (>=4).

Ports:
- hba_clk  in  1  bus clock.
- hba_reset  in  1  asynchronous, active-high reset.
- m_req  in  NUM_MASTERS  per-master transfer request, level.
- m_rnw  in  NUM_MASTERS  per-master 1=read, 0=write.
- m_abus  in  NUM_MASTERS*ADDR_WIDTH  per-master address; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_dbus  in  NUM_MASTERS*DBUS_WIDTH  per-master write data; same packing.
- m_grant  out  NUM_MASTERS  one-hot; high while master i owns the bus.
- m_xferack  out  NUM_MASTERS  one-cycle completion pulse to master i.
- m_err  out  NUM_MASTERS  high together with m_xferack when the transfer timed out.
- m_rdata  out  DBUS_WIDTH  read data, shared; valid in the m_xferack cycle.
- hba_rnw  out  1  bus read/write.
- hba_select  out  1  bus transfer in progress.
- hba_abus  out  ADDR_WIDTH  bus address.
- hba_dbus  out  DBUS_WIDTH  bus write data.
- hba_xferack  in  1  OR of all slave xferack outputs.
- hba_dbus_slave  in  DBUS_WIDTH  OR of all slave data outputs.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - every output is 0;
  - state=IDLE;
  - rr pointer=NUM_MASTERS-1, so master 0 wins first;
  - timeout counter=0.
- Reset asserted mid-transfer aborts immediately. No m_xferack is issued for the aborted transfer.
- All outputs are registered.
- hba_rnw, hba_abus and hba_dbus are 0 whenever hba_select=0. Slaves rely on inactive bus signals being zero.
- Master protocol:
  - Master holds m_req, m_rnw, m_abus and m_dbus stable until its m_xferack.
  - Master must drop m_req in the m_xferack cycle unless it wants another transfer.
  - m_req dropped early is ignored: the transfer completes and acks normally.
- IDLE:
  - If any m_req is set, pick the first requester searching upward (with wrap) from rr pointer+1.
  - Latch that requester's rnw/abus/dbus onto the bus.
  - Set hba_select=1 and set the requester's m_grant bit.
  - Set rr pointer to the winner, clear the counter, go to ACTIVE.
  - Requests are sampled only in IDLE.
- ACTIVE:
  - Bus signals are held constant and the counter increments.
  - If hba_xferack=1 at an edge: capture hba_dbus_slave into m_rdata (rdata=0 for writes), pulse m_xferack[winner] for one cycle, drive hba_select and the bus to 0, clear m_grant, go to RELEASE.
  - Else, if counter==TIMEOUT_CYCLES-1: same exit, but m_rdata=0 and m_err[winner]=1 for the ack cycle.
  - hba_xferack takes priority if it coincides with timeout expiry, so no error is flagged.
- RELEASE:
  - One cycle with hba_select=0, so slave address-hit and ack logic clears.
  - m_xferack, m_err and m_rdata return to 0; go to IDLE.
- hba_xferack seen outside ACTIVE is ignored.
- Throughput: one transfer per (slave latency + 3) cycles minimum.
- Back-to-back from the same master is allowed if no other master requests.
- Fairness: with all masters requesting, grant order is 0,1,...,N-1,0,...
- The counter saturates behaviour-wise because the exit at TIMEOUT_CYCLES-1 is forced.
- Counter width is clog2(TIMEOUT_CYCLES)+1.

Test Plan:
- Reset, then m_req[0] read of addr 0x002 (reg-bank slave at periph 0, reg2=0x5A):
  - hba_select rises the edge after req is sampled;
  - slave acks 3 cycles later;
  - m_xferack[0]=1 with m_rdata=0x5A and m_err=0;
  - hba_select is low in the ack cycle and the RELEASE cycle.
- m_req[1] write 0xC3 to addr 0x001, then a read of 0x001 -> second transfer returns m_rdata=0xC3; bus signals are 0 between transfers.
- Both m_req held continuously for 6 transfers -> grant sequence 0,1,0,1,0,1; m_grant is always one-hot or zero; no master starves.
- Read of unmapped periph 0xF00 -> no hba_xferack:
  - after exactly 16 ACTIVE cycles, m_xferack[0]=1 with m_err[0]=1 and m_rdata=0;
  - the next transfer to 0x000 succeeds.
- hba_xferack arriving on the timeout-expiry cycle (stub slave) -> m_err=0 and data captured.
- hba_reset asserted asynchronously mid-ACTIVE -> all outputs 0 immediately; no m_xferack; the next grant goes to master 0.
